// File: rtl/flag_sync_pkg.sv
// Shared constants for the toggle-flag CDC receiver: mode names, synchronizer depth limits
// and the control FSM state encoding.
package flag_sync_pkg;

  localparam string MODE_PULSE  = "PULSE";
  localparam string MODE_STICKY = "STICKY";

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/flag_sync_rx_chan.sv
// One receive channel: toggle synchronizer, edge detect against the last accepted level,
// flag generation (pulse or sticky) and, with FLAG_SYNC_RX_COUNT_EN, a saturating event counter.
module flag_sync_rx_chan #(
  parameter int unsigned SyncStages = 2,
  parameter bit          Sticky     = 1'b0
`ifdef FLAG_SYNC_RX_COUNT_EN
  ,
  parameter int unsigned CntWidth   = 8
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                run_i,
  input  logic                toggle_i,
  input  logic                flag_clr_i,
`ifdef FLAG_SYNC_RX_COUNT_EN
  input  logic                cnt_clr_i,
  output logic [CntWidth-1:0] count_o,
`endif
  output logic                ack_o,
  output logic                flag_o
);

  (* ASYNC_REG = "TRUE" *) logic [SyncStages-1:0] sync_q;
  logic [SyncStages-1:0] sync_d;
  logic                  last_q, last_d;
  logic                  flag_q, flag_d;
  logic                  synced;
  logic                  edge_det;
  logic                  accept;

  assign sync_d   = {sync_q[SyncStages-2:0], toggle_i};
  assign synced   = sync_q[SyncStages-1];
  assign edge_det = synced ^ last_q;

  always_comb begin
    last_d = last_q;
    flag_d = flag_q;
    accept = 1'b0;
    if (!run_i) begin
      // Blanking: track the synced level so a toggle held high across reset is not an event.
      last_d = synced;
      flag_d = 1'b0;
    end else if (!Sticky) begin
      last_d = synced;
      flag_d = edge_det;
      accept = edge_det;
    end else if (edge_det && (!flag_q || flag_clr_i)) begin
      last_d = synced;
      flag_d = 1'b1;
      accept = 1'b1;
    end else if (flag_clr_i) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      flag_q <= flag_d;
    end
  end

  assign ack_o  = last_q;
  assign flag_o = flag_q;

`ifdef FLAG_SYNC_RX_COUNT_EN
  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = accept ? CntWidth'(1) : '0;
    end else if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
`endif

endmodule

// File: rtl/flag_sync_rx_multi.sv
// Multi-channel toggle-flag CDC receiver: shared post-reset blanking FSM plus NCH channels.
// Define FLAG_SYNC_RX_COUNT_EN to add per-channel saturating event counters.
module flag_sync_rx_multi
  import flag_sync_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter string       MODE        = "PULSE",
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           toggle_in,
  output logic [NCH-1:0]           toggle_ack,
  output logic [NCH-1:0]           flag_out,
  input  logic [NCH-1:0]           flag_clr,
`ifdef FLAG_SYNC_RX_COUNT_EN
  input  logic [NCH-1:0]           cnt_clr,
  output logic [NCH*CNT_WIDTH-1:0] event_count,
`endif
  output logic                     ready
);

  localparam bit          Sticky    = (MODE == MODE_STICKY);
  localparam logic [2:0]  BlankLast = 3'(SYNC_STAGES);

  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("flag_sync_rx_multi: NCH must be 1..32");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("flag_sync_rx_multi: SYNC_STAGES must be 2..4");
  end
  if (MODE != MODE_PULSE && MODE != MODE_STICKY) begin : g_bad_mode
    $error("flag_sync_rx_multi: MODE must be PULSE or STICKY");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("flag_sync_rx_multi: CNT_WIDTH must be at least 1");
  end

  state_e     state_q, state_d;
  logic [2:0] blank_cnt_q, blank_cnt_d;
  logic       ready_q, ready_d;
  logic       run;

  // Stay in BLANK for SYNC_STAGES+1 cycles so every chain has flushed into last.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    unique case (state_q)
      ST_BLANK: begin
        if (blank_cnt_q == BlankLast) begin
          state_d = ST_RUN;
        end else begin
          blank_cnt_d = blank_cnt_q + 3'd1;
        end
      end
      ST_RUN: ;
      default: state_d = ST_BLANK;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      blank_cnt_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      ready_q     <= ready_d;
    end
  end

  assign run   = (state_q == ST_RUN);
  assign ready = ready_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    flag_sync_rx_chan #(
      .SyncStages (SYNC_STAGES),
      .Sticky     (Sticky)
`ifdef FLAG_SYNC_RX_COUNT_EN
      ,
      .CntWidth   (CNT_WIDTH)
`endif
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .run_i      (run),
      .toggle_i   (toggle_in[i]),
      .flag_clr_i (flag_clr[i]),
`ifdef FLAG_SYNC_RX_COUNT_EN
      .cnt_clr_i  (cnt_clr[i]),
      .count_o    (event_count[i*CNT_WIDTH +: CNT_WIDTH]),
`endif
      .ack_o      (toggle_ack[i]),
      .flag_o     (flag_out[i])
    );
  end

endmodule
